// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with write-first bypass and a
// per-register pending-write scoreboard that produces the decode RAW/WAW stall.
module regfile_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int CNTW = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_stall,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  function automatic logic [CNTW-1:0] cnt_inc(input logic [CNTW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  function automatic logic [CNTW-1:0] cnt_dec(input logic [CNTW-1:0] c);
    return (c == '0) ? c : c - CNT_ONE;
  endfunction

  logic [NREG-1:0][XLEN-1:0] rf;
  logic [NREG-1:0][CNTW-1:0] pend;
  logic [NREG-1:0][CNTW-1:0] pend_next;
  logic [NRD-1:0][AW-1:0]    rd_addr_a;
  logic [NRD-1:0][XLEN-1:0]  rd_val;
  logic [NRD-1:0]            rd_hazard;
  logic                      iss_sat;
  logic                      iss_fire;
  logic                      wb_we;

  assign rd_addr_a = rd_addr;
  assign wb_we     = wb_valid && (wb_rd != '0);

  // A source or destination hazard is forgiven when this cycle's writeback
  // retires the last outstanding write (or frees a saturated slot).
  always_comb begin
    iss_sat   = (pend[iss_rd] == CNT_MAX) && !(wb_valid && (wb_rd == iss_rd));
    rd_hazard = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_hazard[i] = rd_en[i] && (rd_addr_a[i] != '0) && (pend[rd_addr_a[i]] != '0) &&
                     !(wb_valid && (wb_rd == rd_addr_a[i]) && (pend[rd_addr_a[i]] == CNT_ONE));
    end
  end

  assign iss_stall = iss_valid && (iss_sat || (|rd_hazard));
  assign iss_fire  = iss_valid && !iss_stall && !flush && (iss_rd != '0);

  always_comb begin
    pend_next = '0;
    for (int r = 1; r < NREG; r++) begin
      if (flush)
        pend_next[r] = '0;
      else if (iss_fire && (iss_rd == AW'(r)) && !(wb_valid && (wb_rd == AW'(r))))
        pend_next[r] = cnt_inc(pend[r]);
      else if (wb_valid && (wb_rd == AW'(r)) && !(iss_fire && (iss_rd == AW'(r))))
        pend_next[r] = cnt_dec(pend[r]);
      else
        pend_next[r] = pend[r];
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr_a[i] == '0)
        rd_val[i] = '0;
      else if (wb_valid && (wb_rd == rd_addr_a[i]))
        rd_val[i] = wb_data;
      else
        rd_val[i] = rf[rd_addr_a[i]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rf <= '0;
    else if (wb_we)
      rf[wb_rd] <= wb_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pend <= '0;
    else
      pend <= pend_next;
  end

  // Read-port registers: busy reflects the counters as they leave this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          rd_data[i*XLEN +: XLEN] <= rd_val[i];
          rd_busy[i]              <= (pend_next[rd_addr_a[i]] != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, RAW/WAW stall,
// flush and asynchronous reset with hand-computed expectations.
module tb_regfile_scoreboard;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int CNTW = 2;
  localparam int AW   = 5;
  localparam logic [63:0] V7 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] V3 = 64'hAAAA_BBBB_CCCC_DDDD;

  logic                clk;
  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_stall;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                flush;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; iss_valid = 1'b0; iss_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en = en; rd_addr = {a1, a0};
  endtask

  task automatic set_wb(input logic v, input logic [AW-1:0] r, input logic [XLEN-1:0] d);
    wb_valid = v; wb_rd = r; wb_data = d;
  endtask

  task automatic set_iss(input logic v, input logic [AW-1:0] r);
    iss_valid = v; iss_rd = r;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (rd_data !== 128'd0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("FAIL reset_rd_busy: got %b want 00", rd_busy); end
    set_iss(1'b1, 5'd5); set_rd(2'b01, 5'd5, 5'd0);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", iss_stall); end
    idle();
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    step();
    set_rd(2'b11, 5'd5, 5'd0);
    step();
    n_cmp++; if (rd_data !== 128'd0) begin n_bad++; $display("FAIL zero_read_data: got %h want 0", rd_data); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("FAIL zero_read_busy: got %b want 00", rd_busy); end
    set_rd(2'b01, 5'd0, 5'd0); set_wb(1'b1, 5'd0, 64'hFFFF);
    step();
    n_cmp++; if (rd_data[63:0] !== 64'd0) begin n_bad++; $display("FAIL x0_bypass: got %h want 0", rd_data[63:0]); end
    set_wb(1'b0, 5'd0, 64'd0);
    step();
    n_cmp++; if (rd_data[63:0] !== 64'd0) begin n_bad++; $display("FAIL x0_after_write: got %h want 0", rd_data[63:0]); end
    idle();
  endtask

  task automatic test_bypass();
    set_rd(2'b10, 5'd0, 5'd7); set_wb(1'b1, 5'd7, V7);
    step();
    n_cmp++; if (rd_data[127:64] !== V7) begin n_bad++; $display("FAIL bypass_p1: got %h want %h", rd_data[127:64], V7); end
    n_cmp++; if (rd_data[63:0] !== 64'd0) begin n_bad++; $display("FAIL bypass_p0_hold: got %h want 0", rd_data[63:0]); end
    idle(); set_rd(2'b01, 5'd7, 5'd0);
    step();
    n_cmp++; if (rd_data[63:0] !== V7) begin n_bad++; $display("FAIL rf_read_x7: got %h want %h", rd_data[63:0], V7); end
    idle();
  endtask

  task automatic test_raw_stall();
    set_iss(1'b1, 5'd3);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL raw_reserve_stall: got %b want 0", iss_stall); end
    step();
    set_iss(1'b1, 5'd10); set_rd(2'b01, 5'd3, 5'd0);
    #1;
    n_cmp++; if (iss_stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall: got %b want 1", iss_stall); end
    step();
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL raw_busy: got %b want 1", rd_busy[0]); end
    set_wb(1'b1, 5'd3, V3);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL raw_wb_release: got %b want 0", iss_stall); end
    step();
    n_cmp++; if (rd_data[63:0] !== V3) begin n_bad++; $display("FAIL raw_wb_data: got %h want %h", rd_data[63:0], V3); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL raw_wb_busy: got %b want 0", rd_busy[0]); end
    idle(); set_rd(2'b01, 5'd10, 5'd0);
    step();
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL raw_x10_reserved: got %b want 1", rd_busy[0]); end
    idle(); set_wb(1'b1, 5'd10, 64'h10);
    step();
    idle();
  endtask

  task automatic test_waw_saturation();
    for (int k = 0; k < 3; k++) begin
      set_iss(1'b1, 5'd9);
      #1;
      n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL waw_accept%0d: got %b want 0", k, iss_stall); end
      step();
    end
    set_iss(1'b1, 5'd9);
    #1;
    n_cmp++; if (iss_stall !== 1'b1) begin n_bad++; $display("FAIL waw_fourth: got %b want 1", iss_stall); end
    step();
    set_wb(1'b1, 5'd9, 64'h99);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL waw_with_wb: got %b want 0", iss_stall); end
    step();
    set_wb(1'b0, 5'd0, 64'd0);
    #1;
    n_cmp++; if (iss_stall !== 1'b1) begin n_bad++; $display("FAIL waw_still_sat: got %b want 1", iss_stall); end
    step();
    idle(); set_rd(2'b01, 5'd9, 5'd0); set_wb(1'b1, 5'd9, 64'h91);
    step();
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL waw_retire1: got %b want 1", rd_busy[0]); end
    set_wb(1'b1, 5'd9, 64'h92);
    step();
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL waw_retire2: got %b want 1", rd_busy[0]); end
    set_wb(1'b1, 5'd9, 64'h93);
    step();
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL waw_retire3: got %b want 0", rd_busy[0]); end
    n_cmp++; if (rd_data[63:0] !== 64'h93) begin n_bad++; $display("FAIL waw_data: got %h want 93", rd_data[63:0]); end
    idle();
  endtask

  task automatic test_flush();
    set_iss(1'b1, 5'd4);
    step();
    set_iss(1'b1, 5'd6);
    step();
    set_iss(1'b1, 5'd11); flush = 1'b1; set_wb(1'b1, 5'd6, 64'h66);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", iss_stall); end
    step();
    idle(); set_rd(2'b11, 5'd4, 5'd11);
    step();
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("FAIL flush_busy: got %b want 00", rd_busy); end
    idle(); set_wb(1'b1, 5'd4, 64'h55); set_rd(2'b01, 5'd4, 5'd0);
    step();
    n_cmp++; if (rd_data[63:0] !== 64'h55) begin n_bad++; $display("FAIL late_wb_data: got %h want 55", rd_data[63:0]); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL late_wb_busy: got %b want 0", rd_busy[0]); end
    idle(); set_iss(1'b1, 5'd0); set_rd(2'b11, 5'd4, 5'd6);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL post_flush_stall: got %b want 0", iss_stall); end
    step();
    n_cmp++; if (rd_data[63:0] !== 64'h55) begin n_bad++; $display("FAIL rf_x4: got %h want 55", rd_data[63:0]); end
    n_cmp++; if (rd_data[127:64] !== 64'h66) begin n_bad++; $display("FAIL rf_x6_flush_wb: got %h want 66", rd_data[127:64]); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("FAIL post_flush_busy: got %b want 00", rd_busy); end
    idle();
  endtask

  task automatic test_async_reset();
    set_iss(1'b1, 5'd2);
    step();
    step();
    idle(); set_rd(2'b11, 5'd2, 5'd7);
    step();
    n_cmp++; if (rd_busy !== 2'b01) begin n_bad++; $display("FAIL pre_reset_busy: got %b want 01", rd_busy); end
    n_cmp++; if (rd_data[127:64] !== V7) begin n_bad++; $display("FAIL pre_reset_x7: got %h want %h", rd_data[127:64], V7); end
    idle();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (rd_data !== 128'd0) begin n_bad++; $display("FAIL async_rd_data: got %h want 0", rd_data); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("FAIL async_rd_busy: got %b want 00", rd_busy); end
    #1 rst = 1'b1;
    set_iss(1'b1, 5'd0); set_rd(2'b11, 5'd2, 5'd7);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL async_stall: got %b want 0", iss_stall); end
    step();
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("FAIL async_pend_cleared: got %b want 00", rd_busy); end
    n_cmp++; if (rd_data !== 128'd0) begin n_bad++; $display("FAIL async_rf_cleared: got %h want 0", rd_data); end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_raw_stall();
    test_waw_saturation();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
